// File: rtl/led_pkg.sv
// Shared constants for the LED output controller: register word indices
// and reset values for the DUTY register and the blink phase.
package led_pkg;

    localparam logic [1:0] LED_REG_DATA   = 2'd0;
    localparam logic [1:0] LED_REG_MASK   = 2'd1;
    localparam logic [1:0] LED_REG_PERIOD = 2'd2;
    localparam logic [1:0] LED_REG_DUTY   = 2'd3;

    // DUTY resets to all-ones; this bit is replicated to the DUTY width.
    localparam logic LED_DUTY_RST_BIT = 1'b1;
    localparam logic LED_PHASE_RST    = 1'b1;

endpackage

// File: rtl/led_blink_timer.sv
// Blink period counter and phase flop. A PERIOD write restarts the
// half-period from zero with phase high.
module led_blink_timer
    import led_pkg::*;
#(
    parameter int BLINK_W = 24
) (
    input  logic               led_clk,
    input  logic               ledrst,
    input  logic [BLINK_W-1:0] period,
    input  logic               period_wr,
    output logic               phase
);

    logic [BLINK_W-1:0] cnt_q, cnt_d;
    logic               phase_q, phase_d;

    // The write restart wins over a wrap landing on the same edge.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (period_wr || (period == '0)) begin
            cnt_d   = '0;
            phase_d = LED_PHASE_RST;
        end else if (cnt_q == (period - BLINK_W'(1))) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + BLINK_W'(1);
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            cnt_q   <= '0;
            phase_q <= LED_PHASE_RST;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/led_ctrl.sv
// MMIO LED controller: static pattern, per-LED blink mask, PWM dimming.
// Define LED_READBACK_EN to add registered register readback on ledrdata.
module led_ctrl
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 24,
    parameter int BLINK_W  = 24,
    parameter int PWM_BITS = 8
) (
    input  logic                led_clk,
    input  logic                ledrst,
    input  logic                ledcs,
    input  logic                ledwrite,
    input  logic [1:0]          ledaddr,
    input  logic [31:0]         ledwdata,
    output logic [31:0]         ledrdata,
    output logic [NUM_LEDS-1:0] ledout
);

    // Bus handshake: a write is ledcs && ledwrite sampled at a rising edge;
    // a read is ledcs && !ledwrite, with data on ledrdata after that edge.
    logic                wr_data, wr_mask, wr_period, wr_duty;
    logic [NUM_LEDS-1:0] data_q, data_d, mask_q, mask_d, ledout_q, ledout_d;
    logic [BLINK_W-1:0]  period_q, period_d;
    logic [PWM_BITS-1:0] duty_q, duty_d, pwm_q, pwm_d;
    logic                phase, pwm_on;
    logic                unused_wdata;

    assign wr_data   = ledcs && ledwrite && (ledaddr == LED_REG_DATA);
    assign wr_mask   = ledcs && ledwrite && (ledaddr == LED_REG_MASK);
    assign wr_period = ledcs && ledwrite && (ledaddr == LED_REG_PERIOD);
    assign wr_duty   = ledcs && ledwrite && (ledaddr == LED_REG_DUTY);
    assign unused_wdata = ^ledwdata;

    led_blink_timer #(.BLINK_W(BLINK_W)) u_blink (
        .led_clk   (led_clk),
        .ledrst    (ledrst),
        .period    (period_q),
        .period_wr (wr_period),
        .phase     (phase)
    );

    // Full-scale DUTY is forced on so the LED never drops out at the wrap.
    assign pwm_on = (&duty_q) || (pwm_q < duty_q);

    always_comb begin
        data_d   = wr_data   ? ledwdata[NUM_LEDS-1:0] : data_q;
        mask_d   = wr_mask   ? ledwdata[NUM_LEDS-1:0] : mask_q;
        period_d = wr_period ? ledwdata[BLINK_W-1:0]  : period_q;
        duty_d   = wr_duty   ? ledwdata[PWM_BITS-1:0] : duty_q;
        pwm_d    = pwm_q + PWM_BITS'(1);
        ledout_d = data_q & (~mask_q | {NUM_LEDS{phase}}) & {NUM_LEDS{pwm_on}};
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            data_q   <= '0;
            mask_q   <= '0;
            period_q <= '0;
            duty_q   <= {PWM_BITS{LED_DUTY_RST_BIT}};
            pwm_q    <= '0;
            ledout_q <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            ledout_q <= ledout_d;
        end
    end

    assign ledout = ledout_q;

`ifdef LED_READBACK_EN
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = '0;
        if (ledcs && !ledwrite) begin
            case (ledaddr)
                LED_REG_DATA:   rdata_d[NUM_LEDS-1:0] = data_q;
                LED_REG_MASK:   rdata_d[NUM_LEDS-1:0] = mask_q;
                LED_REG_PERIOD: rdata_d[BLINK_W-1:0]  = period_q;
                LED_REG_DUTY:   rdata_d[PWM_BITS-1:0] = duty_q;
                default:        rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign ledrdata = rdata_q;
`else
    assign ledrdata = 32'h0;
`endif

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl (24 LEDs, 24-bit period, 8-bit PWM): directed cases
// plus random bus traffic scored cycle by cycle against a reference model.
module tb_led_ctrl;

    logic        led_clk = 1'b0;
    logic        ledrst;
    logic        ledcs;
    logic        ledwrite;
    logic [1:0]  ledaddr;
    logic [31:0] ledwdata;
    logic [31:0] ledrdata;
    logic [23:0] ledout;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // Scoreboard entry: {ledrdata, ledout} expected after a given edge.
    logic [55:0] exp_q[$];
    logic [55:0] mon_e;

    // Reference model: register contents plus edge counts.
    logic [23:0] m_data, m_mask, m_period;
    logic [7:0]  m_duty;
    int          m_k;   // edges completed since reset
    int          m_w;   // value of m_k when the blink half-period last restarted

    led_ctrl #(.NUM_LEDS(24), .BLINK_W(24), .PWM_BITS(8)) dut (
        .led_clk  (led_clk),
        .ledrst   (ledrst),
        .ledcs    (ledcs),
        .ledwrite (ledwrite),
        .ledaddr  (ledaddr),
        .ledwdata (ledwdata),
        .ledrdata (ledrdata),
        .ledout   (ledout)
    );

    always #5 led_clk = ~led_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response of the edge about to happen, from the pre-edge model state.
    function automatic logic [55:0] model_resp(input logic rd, input logic [1:0] a);
        int          el;
        logic        ph;
        logic        on;
        logic [23:0] lo;
        logic [31:0] rv;
        el = m_k - m_w;
        ph = (m_period == 24'd0) ? 1'b1 : (((el / int'(m_period)) % 2) == 0);
        on = (m_duty == 8'hFF) || ((m_k % 256) < int'(m_duty));
        lo = on ? (m_data & (~m_mask | (ph ? 24'hFFFFFF : 24'h000000))) : 24'h0;
        rv = 32'h0;
`ifdef LED_READBACK_EN
        if (rd) begin
            case (a)
                2'd0:    rv = {8'h0, m_data};
                2'd1:    rv = {8'h0, m_mask};
                2'd2:    rv = {8'h0, m_period};
                default: rv = {24'h0, m_duty};
            endcase
        end
`endif
        return {rv, lo};
    endfunction

    always @(posedge led_clk or posedge ledrst) begin
        if (ledrst) begin
            m_data   <= '0;
            m_mask   <= '0;
            m_period <= '0;
            m_duty   <= 8'hFF;
            m_k      <= 0;
            m_w      <= 0;
            exp_q.delete();
        end else begin
            exp_q.push_back(model_resp(ledcs && !ledwrite, ledaddr));
            if (ledcs && ledwrite) begin
                case (ledaddr)
                    2'd0: m_data <= ledwdata[23:0];
                    2'd1: m_mask <= ledwdata[23:0];
                    2'd2: begin
                        m_period <= ledwdata[23:0];
                        m_w      <= m_k + 1;
                    end
                    default: m_duty <= ledwdata[7:0];
                endcase
            end
            m_k <= m_k + 1;
        end
    end

    always @(negedge led_clk) begin
        if (!ledrst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            pops++;
            check("sb_ledout", {8'h0, ledout}, {8'h0, mon_e[23:0]});
            check("sb_ledrdata", ledrdata, mon_e[55:24]);
        end
    end

    task automatic bus(input logic cs, input logic wr, input logic [1:0] a, input logic [31:0] d);
        ledcs    = cs;
        ledwrite = wr;
        ledaddr  = a;
        ledwdata = d;
        @(negedge led_clk);
        ledcs    = 1'b0;
        ledwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge led_clk);
    endtask

    // Called on a negedge; pulses reset for 1 ns between edges.
    task automatic pulse_reset();
        #2 ledrst = 1'b1;
        #1;
        check("rst_ledout", {8'h0, ledout}, 32'h0);
        check("rst_ledrdata", ledrdata, 32'h0);
        ledrst = 1'b0;
        @(negedge led_clk);
    endtask

    // Called right after a PERIOD=3 write with DATA=FF, MASK=0F.
    task automatic blink_pattern(input string name, input int n);
        for (int k = 1; k <= n; k++) begin
            @(negedge led_clk);
            check(name, {8'h0, ledout}, (((k - 1) / 3) % 2 == 0) ? 32'h0000FF : 32'h0000F0);
        end
    endtask

    task automatic count_high(input string name, input int exp);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            @(negedge led_clk);
            if (ledout[0]) cnt++;
        end
        check(name, cnt, exp);
    endtask

    initial begin
        logic [1:0]  a;
        logic [31:0] d;
        int          r;
        ledrst   = 1'b1;
        ledcs    = 1'b0;
        ledwrite = 1'b0;
        ledaddr  = 2'd0;
        ledwdata = 32'h0;
        idle(3);
        check("reset_ledout", {8'h0, ledout}, 32'h0);
        check("reset_ledrdata", ledrdata, 32'h0);
        ledrst = 1'b0;
        idle(2);

        // Static pattern, 2-edge latency, deselected writes ignored.
        bus(1'b1, 1'b1, 2'd0, 32'hFFAA_5501);
        check("data_latency_edge1", {8'h0, ledout}, 32'h0);
        @(negedge led_clk);
        check("data_out", {8'h0, ledout}, 32'h00AA5501);
        idle(5);
        check("data_steady", {8'h0, ledout}, 32'h00AA5501);
        bus(1'b0, 1'b1, 2'd0, 32'h0000_0000);
        idle(3);
        check("cs_low_ignored", {8'h0, ledout}, 32'h00AA5501);
        bus(1'b1, 1'b0, 2'd0, 32'h0000_0000);
        idle(3);
        check("write_low_ignored", {8'h0, ledout}, 32'h00AA5501);

        // Blink with 3-cycle half-periods.
        bus(1'b1, 1'b1, 2'd0, 32'h0000_00FF);
        bus(1'b1, 1'b1, 2'd1, 32'h0000_000F);
        bus(1'b1, 1'b1, 2'd2, 32'h0000_0003);
        blink_pattern("blink", 18);

        // PERIOD rewrites at every offset within a blink cycle, including the wrap.
        for (int off = 0; off < 6; off++) begin
            idle(off);
            bus(1'b1, 1'b1, 2'd2, 32'h0000_0003);
            blink_pattern("period_rewrite", 9);
        end

        // PWM duty.
        bus(1'b1, 1'b1, 2'd2, 32'h0);
        bus(1'b1, 1'b1, 2'd1, 32'h0);
        bus(1'b1, 1'b1, 2'd0, 32'h0000_0001);
        bus(1'b1, 1'b1, 2'd3, 32'h0000_0040);
        idle(2);
        count_high("pwm_duty64", 64);
        bus(1'b1, 1'b1, 2'd3, 32'h0000_0000);
        idle(2);
        count_high("pwm_duty0", 0);
        bus(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
        idle(2);
        count_high("pwm_duty255", 256);

        // Reset mid-blink returns everything to reset values.
        bus(1'b1, 1'b1, 2'd3, 32'h0000_0080);
        bus(1'b1, 1'b1, 2'd0, 32'h0000_00FF);
        bus(1'b1, 1'b1, 2'd1, 32'h0000_000F);
        bus(1'b1, 1'b1, 2'd2, 32'h0000_0003);
        idle(4);
        pulse_reset();
        idle(3);
        check("post_reset_ledout", {8'h0, ledout}, 32'h0);
        bus(1'b1, 1'b1, 2'd0, 32'h0000_00FF);
        @(negedge led_clk);
        check("post_reset_defaults", {8'h0, ledout}, 32'h0000_00FF);

        // Readback.
        bus(1'b1, 1'b1, 2'd2, 32'h0012_3456);
        bus(1'b1, 1'b0, 2'd2, 32'h0);
`ifdef LED_READBACK_EN
        check("readback_period", ledrdata, 32'h0012_3456);
`else
        check("readback_disabled", ledrdata, 32'h0);
`endif
        @(negedge led_clk);
        check("readback_idle", ledrdata, 32'h0);

        // Random traffic; the scoreboard checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                idle(1);
            end else if (r == 9 && $urandom_range(0, 59) == 0) begin
                pulse_reset();
            end else begin
                a = 2'($urandom_range(0, 3));
                d = (a == 2'd2) ? (($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 9))) : $urandom;
                bus($urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0, a, d);
            end
        end

        idle(2);
        check("monitor_active", 32'(pops > 1000), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
